// File: rtl/usr_seq_pkg.sv
// Shared types and defaults for the universal shift-register sequencer.
package usr_seq_pkg;

  localparam int unsigned WIDTH_DEFAULT = 4;
  localparam int unsigned CNT_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHR  = 2'b01,
    OP_SHL  = 2'b10,
    OP_ROTR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Datapath mode encoding: 00 hold, 01 right, 10 left, 11 load.
  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_RIGHT = 2'b01,
    MODE_LEFT  = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

endpackage

// File: rtl/usr_datapath.sv
// WIDTH-bit universal shift register with hold/right/left/load modes and a serial-out flop.
module usr_datapath
  import usr_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  mode_e            mode_i,
  input  logic             si_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] q_o,
  output logic             so_o
);

  logic [WIDTH-1:0] q_d, q_q;
  logic             so_d, so_q;

  always_comb begin
    q_d  = q_q;
    so_d = so_q;
    unique case (mode_i)
      MODE_HOLD: ;
      MODE_RIGHT: begin
        q_d  = {si_i, q_q[WIDTH-1:1]};
        so_d = q_q[0];
      end
      MODE_LEFT: begin
        q_d  = {q_q[WIDTH-2:0], si_i};
        so_d = q_q[WIDTH-1];
      end
      MODE_LOAD: q_d = data_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q  <= '0;
      so_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      so_q <= so_d;
    end
  end

  assign q_o  = q_q;
  assign so_o = so_q;

endmodule

// File: rtl/usr_shift_sequencer.sv
// Command-driven sequencer for a universal shift register: load, shift right/left with repeat count.
// Optional macro USR_SEQ_ROTATE_EN turns op 11 into rotate-right; otherwise op 11 flags err.
module usr_shift_sequencer
  import usr_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_si,
  output logic [WIDTH-1:0] q,
  output logic             so,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state_d, state_q;
  op_e              op_d, op_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [WIDTH-1:0] data_d, data_q;
  logic             si_d, si_q;
  logic             done_d, done_q;
  logic             err_d, err_q;
  logic             busy_d, busy_q;

  mode_e            mode;
  logic             dp_si;
  logic             shift_en;
  logic             finish;

  assign cmd_ready = (state_q == ST_IDLE) && RES;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    si_d     = si_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    mode     = MODE_HOLD;
    dp_si    = si_q;
    shift_en = 1'b0;
    finish   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = op_e'(cmd_op);
          cnt_d   = cmd_cnt;
          data_d  = cmd_data;
          si_d    = cmd_si;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        finish = 1'b1;
        case (op_q)
          OP_LOAD: mode = MODE_LOAD;
          OP_SHR, OP_SHL: shift_en = 1'b1;
`ifdef USR_SEQ_ROTATE_EN
          // Rotate is a right shift whose serial input is the bit falling off the bottom.
          OP_ROTR: begin
            shift_en = 1'b1;
            dp_si    = q[0];
          end
`else
          OP_ROTR: err_d = 1'b1;
`endif
          default: ;
        endcase
        // A zero count finishes immediately with the register untouched.
        if (shift_en && (cnt_q != '0)) begin
          mode   = (op_q == OP_SHL) ? MODE_LEFT : MODE_RIGHT;
          cnt_d  = cnt_q - CNT_W'(1);
          finish = (cnt_q == CNT_W'(1));
        end
        if (finish) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          err_d = 1'b0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOAD;
      cnt_q   <= '0;
      data_q  <= '0;
      si_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      si_q    <= si_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign done = done_q;
  assign err  = err_q;
  assign busy = busy_q;

  usr_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk_i (CLK),
    .rst_ni(RES),
    .mode_i(mode),
    .si_i  (dp_si),
    .data_i(data_q),
    .q_o   (q),
    .so_o  (so)
  );

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Directed bench for usr_shift_sequencer with a per-cycle expected-output scoreboard.
module tb_usr_shift_sequencer;

  localparam int W = 4;
  localparam int C = 4;
`ifdef USR_SEQ_ROTATE_EN
  localparam bit Rot = 1'b1;
`else
  localparam bit Rot = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RES = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = '0;
  logic [C-1:0] cmd_cnt = '0;
  logic [W-1:0] cmd_data = '0;
  logic         cmd_si = 1'b0;
  logic [W-1:0] q;
  logic         so, busy, done, err;

  typedef struct packed {
    logic [W-1:0] q;
    logic         so;
    logic         done;
    logic         err;
    logic         busy;
    logic         rdy;
  } exp_t;

  exp_t         sb[$];
  int           n_tests = 0;
  int           n_fail = 0;
  logic [W-1:0] mq = '0;
  logic         mso = 1'b0;

  usr_shift_sequencer #(
    .WIDTH(W),
    .CNT_W(C)
  ) dut (
    .CLK      (CLK),
    .RES      (RES),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_cnt  (cmd_cnt),
    .cmd_data (cmd_data),
    .cmd_si   (cmd_si),
    .q        (q),
    .so       (so),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic d, input logic e, input logic b, input logic r);
    exp_t x;
    x.q = mq; x.so = mso; x.done = d; x.err = e; x.busy = b; x.rdy = r;
    sb.push_back(x);
  endtask

  // Drive one command through the handshake and queue the expected per-edge outputs.
  task automatic send(input logic [1:0] op, input logic [C-1:0] cnt, input logic [W-1:0] data,
                      input logic si, input bit hold);
    int waited = 0;
    while (cmd_ready !== 1'b1 && waited < 20) begin
      @(posedge CLK); #1;
      waited++;
    end
    chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_cnt = cnt; cmd_data = data; cmd_si = si;
    @(posedge CLK); #1;
    if (!hold) cmd_valid = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("ready_after_accept", 32'(cmd_ready), 32'd0);
    if (op == 2'b00) begin
      mq = data;
      push(1'b1, 1'b0, 1'b1, 1'b0);
    end else if (op == 2'b11 && !Rot) begin
      push(1'b1, 1'b1, 1'b1, 1'b0);
    end else if (cnt == '0) begin
      push(1'b1, 1'b0, 1'b1, 1'b0);
    end else begin
      for (int i = 1; i <= int'(cnt); i++) begin
        if (op == 2'b01) begin
          mso = mq[0]; mq = {si, mq[W-1:1]};
        end else if (op == 2'b10) begin
          mso = mq[W-1]; mq = {mq[W-2:0], si};
        end else begin
          mso = mq[0]; mq = {mq[0], mq[W-1:1]};
        end
        push(i == int'(cnt), 1'b0, 1'b1, 1'b0);
      end
    end
    push(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic drain(input int n);
    exp_t e;
    for (int k = 0; k < n && sb.size() > 0; k++) begin
      @(posedge CLK); #1;
      e = sb.pop_front();
      chk("q", 32'(q), 32'(e.q));
      chk("so", 32'(so), 32'(e.so));
      chk("done", 32'(done), 32'(e.done));
      chk("err", 32'(err), 32'(e.err));
      chk("busy", 32'(busy), 32'(e.busy));
      chk("cmd_ready", 32'(cmd_ready), 32'(e.rdy));
    end
  endtask

  initial begin
    #12;
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_so", 32'(so), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    @(negedge CLK); RES = 1'b1;
    @(posedge CLK); #1;
    chk("ready_out_of_reset", 32'(cmd_ready), 32'd1);

    // Reset in the middle of a SHL cnt=5, just after its third shift.
    send(2'b10, 4'd5, 4'b0000, 1'b1, 1'b0);
    drain(3);
    #2 RES = 1'b0;
    #1;
    chk("abort_q", 32'(q), 32'd0);
    chk("abort_so", 32'(so), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ready", 32'(cmd_ready), 32'd0);
    sb.delete();
    mq = '0; mso = 1'b0;
    repeat (3) begin
      @(posedge CLK); #1;
      chk("abort_no_done", 32'(done), 32'd0);
    end
    @(negedge CLK); RES = 1'b1;
    @(posedge CLK); #1;
    chk("abort_ready_after", 32'(cmd_ready), 32'd1);
    chk("abort_busy_after", 32'(busy), 32'd0);
    chk("abort_done_after", 32'(done), 32'd0);

    send(2'b00, 4'd0, 4'b1011, 1'b0, 1'b0);   // LOAD 1011
    drain(100);
    send(2'b01, 4'd2, 4'b0000, 1'b0, 1'b0);   // SHR x2 si=0
    drain(100);
    send(2'b10, 4'd3, 4'b0000, 1'b1, 1'b1);   // SHL x3 si=1, valid held high
    drain(100);
    cmd_valid = 1'b0;
    chk("no_reaccept_busy", 32'(busy), 32'd0);
    send(2'b01, 4'd0, 4'b0000, 1'b1, 1'b0);   // SHR x0
    drain(100);
    send(2'b11, 4'd1, 4'b0000, 1'b0, 1'b0);   // op 11 from 0111
    drain(100);
    send(2'b00, 4'd0, 4'b0110, 1'b0, 1'b0);
    drain(100);
    send(2'b01, 4'd15, 4'b0000, 1'b1, 1'b0);  // maximum count
    drain(100);
    send(2'b10, 4'd15, 4'b0000, 1'b0, 1'b0);
    drain(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/usr_shift_sequencer.md
# usr_shift_sequencer

Command-driven controller that sequences a WIDTH-bit universal shift register through load, shift-right and shift-left operations, each with a programmable repeat count. An upstream agent issues one command per valid/ready handshake. The block applies the mode selection and serial input cycle by cycle, then pulses `done`. It sits between a host or test sequencer and the shift-register datapath, which it owns internally, and exposes the register contents and the serial-out bit.

## Interface
- `WIDTH`, 4: register width in bits.
- `CNT_W`, 4: width of the shift-count field.

- `CLK`  in  1  rising-edge clock.
- `RES`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_op`  in  2  operation code: 00 LOAD, 01 SHR, 10 SHL, 11 ROTR/illegal.
- `cmd_cnt`  in  CNT_W  number of shifts (ignored for LOAD).
- `cmd_data`  in  WIDTH  parallel load value.
- `cmd_si`  in  1  serial input used for every shift of this command.
- `q`  out  WIDTH  register contents.
- `so`  out  1  last bit shifted out.
- `busy`  out  1  a command is executing.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse, coincident with `done`, for an illegal op.

## Operation
- **FSM states:** IDLE, EXEC, DONE.
- **Handshake:** `cmd_ready` = (state==IDLE) && RES high. A command is accepted at a rising edge where `cmd_valid && cmd_ready`.
  - op, cnt, data and si are latched at that edge, and the state moves to EXEC.
  - `cmd_valid` outside IDLE is ignored. Fields need to be stable only at the handshake edge.
- **EXEC, LOAD:** `q` <= data, then go to DONE.
- **EXEC, shift with remaining==0:** no change to `q`, then go to DONE.
- **EXEC, shift with remaining>0:** shift once and decrement remaining. Go to DONE when remaining was 1.
- **Shift rules:**
  - SHR: `q` <= {si, q[W-1:1]}, `so` <= q[0].
  - SHL: `q` <= {q[W-2:0], si}, `so` <= q[W-1].
- **DONE:** `done`=1 for exactly one cycle, then return to IDLE.
- **`busy`:** 1 in EXEC and DONE.
- **Counter:** CNT_W wide, no wrap. The maximum count 2^CNT_W−1 is legal.
- **Reset values:** `q`=0, `so`=0, `busy`=0, `done`=0, `err`=0, `cmd_ready`=0 while RES is low. State is IDLE.
- **Reset mid-command:** aborts immediately with no `done`. The latched command is discarded.

## Timing
- **LOAD:** accept at edge E0; `q` is updated at E1; `done` is high between E1 and E2; `cmd_ready` returns at E2.
- **Shift by N (N≥1):** shifts occur at edges E1…EN; `done` is high between EN and EN+1.
- **Shift by N=0:** behaves like LOAD timing, with `q` unchanged.
- **Throughput:** the next command is accepted no earlier than edge EN+1 (E2 for LOAD and N=0).
- **Outputs:** all outputs are registered except `cmd_ready`, which is decoded from state and RES.

## Configuration
- **Macro:** `USR_SEQ_ROTATE_EN`.
- **Defined:** op 11 is ROTR. Each step does `q` <= {q[0], q[W-1:1]} and `so` <= q[0]. `cmd_si` is ignored. Timing matches SHR.
- **Undefined:** op 11 is illegal.
  - It is accepted, spends one EXEC cycle with no change to `q` or `so`, then enters DONE.
  - `err` pulses together with `done`.

## Structure
- **Package `usr_seq_pkg`:**
  - op enum (`OP_LOAD`, `OP_SHR`, `OP_SHL`, `OP_ROTR`);
  - state enum (`ST_IDLE`, `ST_EXEC`, `ST_DONE`);
  - default WIDTH and CNT_W constants.
- **Sub-module `usr_datapath`:** the WIDTH-bit register with a 2-bit mode input (00 hold, 01 right, 10 left, 11 load), `si`, parallel input and `so`. ROTR is realised by feeding q[0] back to `si` with mode 01.
- **Top level:** holds the FSM, the command latch, the remaining counter and the mode decode.

## Test plan
1. RES low during a SHL with cnt=5 at its third shift -> `q`=0000, `busy`=0, `done` never pulses. After RES rises, `cmd_ready`=1.
2. LOAD data=1011 -> `q`=1011 one edge after accept; `done` pulses for 1 cycle; `err`=0.
3. From 1011, SHR cnt=2 si=0 -> `q` is 0101 then 0010, `so`=1 after each shift, `done` after the 2nd shift.
4. From 0010, SHL cnt=3 si=1 -> `q` is 0101, 1011, 0111; `so` is 0, 0, 1. `cmd_valid` held high throughout is not accepted again until after `done`.
5. SHR cnt=0 -> `q` unchanged; `done` one edge after accept.
6. From 0111, op=11 cnt=1:
   - without the macro -> `q`=0111, `err`=1 and `done`=1 in the same cycle;
   - with `USR_SEQ_ROTATE_EN` -> `q`=1011, `so`=1, `err`=0.
